// File: rtl/vx_csr_access.sv
// CSR access unit: two-stage read-modify-write pipeline in front of the CSR file.
// S0 reads the CSR combinationally; S1 holds the entry until the response fires.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef VX_CSR_ADDR_BITS
`define VX_CSR_ADDR_BITS 12
`endif

module vx_csr_access #(
    parameter string INSTANCE_ID = "",
    parameter int    CORE_ID     = 0,
    parameter int    UUID_WIDTH  = 8,
    parameter int    NW_WIDTH    = 4
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [UUID_WIDTH-1:0]        req_uuid,
    input  logic [NW_WIDTH-1:0]          req_wid,
    input  logic [1:0]                   req_op,
    input  logic [`VX_CSR_ADDR_BITS-1:0] req_addr,
    input  logic [`XLEN-1:0]             req_src,
    input  logic                         req_src_zero,
    input  logic [4:0]                   req_rd,
    input  logic                         req_wb,

    output logic                         read_enable,
    output logic [UUID_WIDTH-1:0]        read_uuid,
    output logic [NW_WIDTH-1:0]          read_wid,
    output logic [`VX_CSR_ADDR_BITS-1:0] read_addr,
    input  logic [`XLEN-1:0]             read_data_ro,
    input  logic [`XLEN-1:0]             read_data_rw,

    output logic                         write_enable,
    output logic [UUID_WIDTH-1:0]        write_uuid,
    output logic [NW_WIDTH-1:0]          write_wid,
    output logic [`VX_CSR_ADDR_BITS-1:0] write_addr,
    output logic [`XLEN-1:0]             write_data,

    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [UUID_WIDTH-1:0]        rsp_uuid,
    output logic [NW_WIDTH-1:0]          rsp_wid,
    output logic [4:0]                   rsp_rd,
    output logic                         rsp_wb,
    output logic [`XLEN-1:0]             rsp_data,
    output logic                         rsp_illegal
);

    localparam int XLEN = `XLEN;
    localparam int AB   = `VX_CSR_ADDR_BITS;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    typedef struct packed {
        logic [UUID_WIDTH-1:0] uuid;
        logic [NW_WIDTH-1:0]   wid;
        logic [AB-1:0]         addr;
        logic [4:0]            rd;
        logic                  wb;
        logic [XLEN-1:0]       old_val;
        logic [XLEN-1:0]       new_val;
        logic                  wr;
        logic                  illegal;
    } s1_t;

    s1_t  s1;
    s1_t  s1_n;
    logic s1_valid;

    logic hazard;
    logic accept;
    logic fire;
    logic wr_intent;
    logic ro_space;
    logic illegal;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;

    assign hazard = s1_valid && s1.wr
                 && (s1.wid == req_wid)
                 && (s1.addr == req_addr);

    assign req_ready = ~hazard && (~s1_valid || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign fire      = s1_valid && rsp_ready;

    // A plain write that discards rd needs no read side effect
    assign read_enable = accept && ~((req_op == OP_RW) && ~req_wb);
    assign read_uuid   = req_uuid;
    assign read_wid    = req_wid;
    assign read_addr   = req_addr;

    assign old_val = read_enable ? (read_data_ro | read_data_rw) : '0;

    // New value and write legality for the request in S0
    always_comb begin
        new_val   = '0;
        wr_intent = 1'b0;
        unique case (req_op)
            OP_RW: begin
                new_val   = req_src;
                wr_intent = 1'b1;
            end
            OP_RS: begin
                new_val   = old_val | req_src;
                wr_intent = ~req_src_zero;
            end
            OP_RC: begin
                new_val   = old_val & ~req_src;
                wr_intent = ~req_src_zero;
            end
            default: begin
                new_val   = '0;
                wr_intent = 1'b0;
            end
        endcase
    end

    assign ro_space = (req_addr[AB-1:AB-2] == 2'b11);
    assign illegal  = (req_op == 2'b00) || (wr_intent && ro_space);

    // Pack the S0 results into the next S1 entry
    always_comb begin
        s1_n         = '0;
        s1_n.uuid    = req_uuid;
        s1_n.wid     = req_wid;
        s1_n.addr    = req_addr;
        s1_n.rd      = req_rd;
        s1_n.wb      = req_wb;
        s1_n.old_val = old_val;
        s1_n.new_val = new_val;
        s1_n.wr      = wr_intent && ~illegal;
        s1_n.illegal = illegal;
    end

    // S1 occupancy: load on accept, drain on fire, refill in the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
        end else if (fire) begin
            s1_valid <= 1'b0;
        end
    end

    // S1 payload is only meaningful while s1_valid, so it needs no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            s1 <= s1_n;
        end
    end

    // Held entries are dropped under reset without committing their write
    assign write_enable = fire && s1.wr && ~reset;
    assign write_uuid   = s1.uuid;
    assign write_wid    = s1.wid;
    assign write_addr   = s1.addr;
    assign write_data   = s1.new_val;

    assign rsp_valid   = s1_valid;
    assign rsp_uuid    = s1.uuid;
    assign rsp_wid     = s1.wid;
    assign rsp_rd      = s1.rd;
    assign rsp_wb      = s1.wb;
    assign rsp_data    = s1.old_val;
    assign rsp_illegal = s1.illegal;

`ifndef SYNTHESIS
    // Reserved opcode must never be issued by the decoder
    always @(posedge clk) begin
        if (!reset && req_valid) begin
            assert (req_op != 2'b00)
            else $error("%s (core %0d): reserved csr op, uuid=%0d",
                        INSTANCE_ID, CORE_ID, req_uuid);
        end
    end
`endif

endmodule
